// File: rtl/chessboard_if.sv
// chessboard_if: scan-side inputs and pixel/cursor/move outputs of the
// chessboard renderer; master drives scan and buttons, slave renders.
interface chessboard_if #(
  parameter int CB = 3
);
  logic [10:0]   x;
  logic [10:0]   y;
  logic          valid;
  logic          frame_start;
  logic          mv_up;
  logic          mv_down;
  logic          mv_left;
  logic          mv_right;
  logic          sel_btn;
  logic [CB-1:0] red;
  logic [CB-1:0] green;
  logic [CB-1:0] blue;
  logic          pix_valid;
  logic [2:0]    cur_row;
  logic [2:0]    cur_col;
  logic          sel_active;
  logic          move_valid;
  logic [5:0]    move_from;
  logic [5:0]    move_to;

  modport master (
    output x, y, valid, frame_start,
    output mv_up, mv_down, mv_left, mv_right,
    output sel_btn,
    input  red, green, blue, pix_valid,
    input  cur_row, cur_col, sel_active,
    input  move_valid, move_from, move_to
  );

  modport slave (
    input  x, y, valid, frame_start,
    input  mv_up, mv_down, mv_left, mv_right,
    input  sel_btn,
    output red, green, blue, pix_valid,
    output cur_row, cur_col, sel_active,
    output move_valid, move_from, move_to
  );
endinterface

// File: rtl/chessboard_renderer.sv
// chessboard_renderer: 2-stage scan->RGB chessboard pipeline with blinking
// cursor, selection FSM and move request. Ports: clk, rst_n, bus (slave).
module chessboard_renderer #(
  parameter int TILE_W       = 160,
  parameter int TILE_H       = 128,
  parameter int BOARD_X0     = 0,
  parameter int BOARD_Y0     = 0,
  parameter int CB           = 3,
  parameter int BORDER_PX    = 4,
  parameter int BLINK_FRAMES = 30,
  parameter int CURSOR_WRAP  = 0,
  parameter logic [3*CB-1:0] LIGHT_RGB  = {3'd2, 3'd2, 3'd7},
  parameter logic [3*CB-1:0] DARK_RGB   = {3'd0, 3'd0, 3'd2},
  parameter logic [3*CB-1:0] CURSOR_RGB = {3'd7, 3'd7, 3'd0},
  parameter logic [3*CB-1:0] SELECT_RGB = {3'd0, 3'd7, 3'd0}
) (
  input  logic        clk,
  input  logic        rst_n,
  chessboard_if.slave bus
);

  localparam bit WRAP = (CURSOR_WRAP != 0);
  localparam int BCW  =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BCW-1:0] B_LAST =
    BCW'(BLINK_FRAMES - 1);

  localparam logic [10:0] BX_LO = 11'(BORDER_PX);
  localparam logic [10:0] BX_HI = 11'(TILE_W - BORDER_PX);
  localparam logic [10:0] BY_LO = 11'(BORDER_PX);
  localparam logic [10:0] BY_HI = 11'(TILE_H - BORDER_PX);

  typedef enum logic {
    IDLE,
    SELECTED
  } state_t;

  typedef struct packed {
    logic        valid;
    logic        on_board;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [10:0] off_x;
    logic [10:0] off_y;
  } s1_t;

  s1_t s1_d, s1_q;

  logic [3*CB-1:0] rgb_d, rgb_q;
  logic            pv_d, pv_q;

  logic [2:0] row_d, row_q;
  logic [2:0] col_d, col_q;

  state_t     state_d, state_q;
  logic [5:0] from_d, from_q;
  logic [5:0] to_d, to_q;
  logic       mv_d, mv_q;

  logic [BCW-1:0] bcnt_d, bcnt_q;
  logic           bon_d, bon_q;

  int rx, ry;

  // Stage 1: board-relative position, split into tile and offset.
  always_comb begin
    rx = int'({21'd0, bus.x}) - BOARD_X0;
    ry = int'({21'd0, bus.y}) - BOARD_Y0;
    s1_d.valid    = bus.valid;
    s1_d.on_board = (rx >= 0) && (rx < 8 * TILE_W) &&
                    (ry >= 0) && (ry < 8 * TILE_H);
    s1_d.row      = 3'(ry / TILE_H);
    s1_d.col      = 3'(rx / TILE_W);
    s1_d.off_x    = 11'(rx % TILE_W);
    s1_d.off_y    = 11'(ry % TILE_H);
  end

  logic brd;
  logic on_cur;
  logic on_sel;

  // Stage 2: colour, using cursor/selection as they are at this edge.
  always_comb begin
    brd    = (s1_q.off_x < BX_LO) || (s1_q.off_x >= BX_HI) ||
             (s1_q.off_y < BY_LO) || (s1_q.off_y >= BY_HI);
    on_cur = (s1_q.row == row_q) && (s1_q.col == col_q);
    on_sel = (state_q == SELECTED) &&
             ({s1_q.row, s1_q.col} == from_q);
    pv_d   = s1_q.valid;
    rgb_d  = '0;
    if (s1_q.valid && s1_q.on_board) begin
      if (on_cur && brd && bon_q) begin
        rgb_d = CURSOR_RGB;
      end else if (on_sel) begin
        rgb_d = SELECT_RGB;
      end else if (s1_q.row[0] ^ s1_q.col[0]) begin
        rgb_d = DARK_RGB;
      end else begin
        rgb_d = LIGHT_RGB;
      end
    end
  end

  // Blink phase advances once per BLINK_FRAMES frame pulses.
  always_comb begin
    bcnt_d = bcnt_q;
    bon_d  = bon_q;
    if (bus.frame_start) begin
      if (bcnt_q == B_LAST) begin
        bcnt_d = '0;
        bon_d  = ~bon_q;
      end else begin
        bcnt_d = bcnt_q + BCW'(1);
      end
    end
  end

  // Opposing pulses cancel; edges saturate or wrap.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (bus.mv_up && !bus.mv_down) begin
      if (row_q != 3'd0) row_d = row_q - 3'd1;
      else if (WRAP) row_d = 3'd7;
    end else if (bus.mv_down && !bus.mv_up) begin
      if (row_q != 3'd7) row_d = row_q + 3'd1;
      else if (WRAP) row_d = 3'd0;
    end
    if (bus.mv_left && !bus.mv_right) begin
      if (col_q != 3'd0) col_d = col_q - 3'd1;
      else if (WRAP) col_d = 3'd7;
    end else if (bus.mv_right && !bus.mv_left) begin
      if (col_q != 3'd7) col_d = col_q + 3'd1;
      else if (WRAP) col_d = 3'd0;
    end
  end

  // Selection sees the pre-move cursor when both happen together.
  always_comb begin
    state_d = state_q;
    from_d  = from_q;
    to_d    = to_q;
    mv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.sel_btn) begin
          state_d = SELECTED;
          from_d  = {row_q, col_q};
        end
      end
      SELECTED: begin
        if (bus.sel_btn) begin
          state_d = IDLE;
          if ({row_q, col_q} != from_q) begin
            mv_d = 1'b1;
            to_d = {row_q, col_q};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      rgb_q   <= '0;
      pv_q    <= 1'b0;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      state_q <= IDLE;
      from_q  <= 6'd0;
      to_q    <= 6'd0;
      mv_q    <= 1'b0;
      bcnt_q  <= '0;
      bon_q   <= 1'b1;
    end else begin
      s1_q    <= s1_d;
      rgb_q   <= rgb_d;
      pv_q    <= pv_d;
      row_q   <= row_d;
      col_q   <= col_d;
      state_q <= state_d;
      from_q  <= from_d;
      to_q    <= to_d;
      mv_q    <= mv_d;
      bcnt_q  <= bcnt_d;
      bon_q   <= bon_d;
    end
  end

  assign bus.red        = rgb_q[3*CB-1:2*CB];
  assign bus.green      = rgb_q[2*CB-1:CB];
  assign bus.blue       = rgb_q[CB-1:0];
  assign bus.pix_valid  = pv_q;
  assign bus.cur_row    = row_q;
  assign bus.cur_col    = col_q;
  assign bus.sel_active = (state_q == SELECTED);
  assign bus.move_valid = mv_q;
  assign bus.move_from  = from_q;
  assign bus.move_to    = to_q;

endmodule

// File: tb/tb_chessboard_renderer.sv
// tb_chessboard_renderer: scoreboard bench for a saturating renderer and a
// wrapping, offset renderer, both checked against a behavioural board model.
module tb_chessboard_renderer;

  localparam int TW = 160;
  localparam int TH = 128;
  localparam int BP = 4;
  localparam int BF = 2;
  localparam logic [8:0] C_LIGHT  = 9'b010_010_111;
  localparam logic [8:0] C_DARK   = 9'b000_000_010;
  localparam logic [8:0] C_CURSOR = 9'b111_111_000;
  localparam logic [8:0] C_SELECT = 9'b000_111_000;

  typedef struct packed {
    int             due;
    logic [1:0][8:0] pix;
    logic [1:0]     pv;
  } pe_t;

  typedef struct packed {
    int              due;
    logic [1:0][2:0] row;
    logic [1:0][2:0] col;
    logic [1:0]      sel;
    logic [1:0][5:0] from;
    logic [1:0][5:0] to;
  } se_t;

  typedef struct packed {
    int due;
    int inst;
  } me_t;

  pe_t pq[$];
  se_t sq[$];
  me_t mq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pi    = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [10:0] x_i, y_i;
  logic v_i, fs_i, up_i, dn_i, lf_i, rt_i, sel_i;

  chessboard_if #(.CB(3)) b0 ();
  chessboard_if #(.CB(3)) b1 ();

  assign b0.x = x_i;
  assign b0.y = y_i;
  assign b0.valid = v_i;
  assign b0.frame_start = fs_i;
  assign b0.mv_up = up_i;
  assign b0.mv_down = dn_i;
  assign b0.mv_left = lf_i;
  assign b0.mv_right = rt_i;
  assign b0.sel_btn = sel_i;
  assign b1.x = x_i;
  assign b1.y = y_i;
  assign b1.valid = v_i;
  assign b1.frame_start = fs_i;
  assign b1.mv_up = up_i;
  assign b1.mv_down = dn_i;
  assign b1.mv_left = lf_i;
  assign b1.mv_right = rt_i;
  assign b1.sel_btn = sel_i;

  chessboard_renderer #(
    .BLINK_FRAMES(BF)
  ) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b0)
  );

  chessboard_renderer #(
    .BLINK_FRAMES(BF),
    .CURSOR_WRAP (1),
    .BOARD_X0    (16),
    .BOARD_Y0    (8)
  ) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b1)
  );

  logic [1:0][8:0] g_pix;
  logic [1:0]      g_pv, g_sel, g_mv;
  logic [1:0][2:0] g_row, g_col;
  logic [1:0][5:0] g_from, g_to;

  assign g_pix  = {{b1.red, b1.green, b1.blue},
                   {b0.red, b0.green, b0.blue}};
  assign g_pv   = {b1.pix_valid, b0.pix_valid};
  assign g_sel  = {b1.sel_active, b0.sel_active};
  assign g_mv   = {b1.move_valid, b0.move_valid};
  assign g_row  = {b1.cur_row, b0.cur_row};
  assign g_col  = {b1.cur_col, b0.cur_col};
  assign g_from = {b1.move_from, b0.move_from};
  assign g_to   = {b1.move_to, b0.move_to};

  // Behavioural model state, one slot per instance.
  int m_row[2], m_col[2], m_cnt[2];
  int m_from[2], m_to[2];
  bit m_sel[2], m_on[2];

  int pts_x[6] = '{0, 3, 159, 80, 1140, 20};
  int pts_y[6] = '{0, 60, 127, 64, 10, 9};

  function automatic int x0_of(int i);
    return (i == 1) ? 16 : 0;
  endfunction

  function automatic int y0_of(int i);
    return (i == 1) ? 8 : 0;
  endfunction

  function automatic int mv(int i, int v);
    if (i == 1) return (v + 8) % 8;
    if (v < 0) return 0;
    if (v > 7) return 7;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_row[i] = 0;
      m_col[i] = 0;
      m_cnt[i] = 0;
      m_from[i] = 0;
      m_to[i] = 0;
      m_sel[i] = 1'b0;
      m_on[i] = 1'b1;
    end
  endfunction

  function automatic logic [8:0] exp_pix(int i, int px, int py, bit v);
    int rx, ry, r, c, ox, oy;
    bit brd;
    if (!v) return 9'd0;
    rx = px - x0_of(i);
    ry = py - y0_of(i);
    if (rx < 0 || ry < 0 || rx >= 8 * TW || ry >= 8 * TH) return 9'd0;
    c = rx / TW;
    r = ry / TH;
    ox = rx % TW;
    oy = ry % TH;
    brd = ox < BP || ox >= TW - BP || oy < BP || oy >= TH - BP;
    if (r == m_row[i] && c == m_col[i] && brd && m_on[i])
      return C_CURSOR;
    if (m_sel[i] && r * 8 + c == m_from[i]) return C_SELECT;
    return ((r + c) % 2 == 1) ? C_DARK : C_LIGHT;
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h",
               nm, i, cyc, got, want);
    end
  endtask

  task automatic step(input int px, input int py, input bit v,
                      input bit fs, input bit u, input bit d,
                      input bit l, input bit r, input bit s);
    pe_t pe;
    se_t se;
    int here;
    @(negedge clk);
    x_i = 11'(px);
    y_i = 11'(py);
    v_i = v;
    fs_i = fs;
    up_i = u;
    dn_i = d;
    lf_i = l;
    rt_i = r;
    sel_i = s;
    for (int i = 0; i < 2; i++) begin
      here = m_row[i] * 8 + m_col[i];
      if (s) begin
        if (!m_sel[i]) begin
          m_sel[i] = 1'b1;
          m_from[i] = here;
        end else begin
          if (here != m_from[i]) begin
            m_to[i] = here;
            mq.push_back('{cyc + 1, i});
          end
          m_sel[i] = 1'b0;
        end
      end
      m_row[i] = mv(i, m_row[i] + int'(d) - int'(u));
      m_col[i] = mv(i, m_col[i] + int'(r) - int'(l));
      if (fs) begin
        m_cnt[i]++;
        if (m_cnt[i] == BF) begin
          m_cnt[i] = 0;
          m_on[i] = !m_on[i];
        end
      end
      pe.pix[i] = exp_pix(i, px, py, v);
      pe.pv[i] = v;
      se.row[i] = 3'(m_row[i]);
      se.col[i] = 3'(m_col[i]);
      se.sel[i] = m_sel[i];
      se.from[i] = 6'(m_from[i]);
      se.to[i] = 6'(m_to[i]);
    end
    pe.due = cyc + 2;
    se.due = cyc + 1;
    pq.push_back(pe);
    sq.push_back(se);
  endtask

  task automatic scan(input int px, input int py, input bit v);
    step(px, py, v, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ctl(input bit u, input bit d, input bit l,
                     input bit r, input bit s, input bit fs);
    step(pts_x[pi % 6], pts_y[pi % 6], 1, fs, u, d, l, r, s);
    pi++;
  endtask

  task automatic drive_idle();
    x_i = '0;
    y_i = '0;
    v_i = 0;
    fs_i = 0;
    up_i = 0;
    dn_i = 0;
    lf_i = 0;
    rt_i = 0;
    sel_i = 0;
  endtask

  task automatic chk_rst();
    for (int i = 0; i < 2; i++) begin
      chk("rst_pix", i, 32'(g_pix[i]), 0);
      chk("rst_pv", i, 32'(g_pv[i]), 0);
      chk("rst_row", i, 32'(g_row[i]), 0);
      chk("rst_col", i, 32'(g_col[i]), 0);
      chk("rst_sel", i, 32'(g_sel[i]), 0);
      chk("rst_mv", i, 32'(g_mv[i]), 0);
      chk("rst_from", i, 32'(g_from[i]), 0);
      chk("rst_to", i, 32'(g_to[i]), 0);
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    pq.delete();
    sq.delete();
    mq.delete();
    model_reset();
    drive_idle();
    #1;
    chk_rst();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops every expectation that falls due this cycle.
  always @(negedge clk) begin
    pe_t pe;
    se_t se;
    bit em;
    if (rst_n === 1'b1) begin
      while (pq.size() > 0 && pq[0].due <= cyc) begin
        pe = pq.pop_front();
        if (pe.due != cyc) begin
          chk("pixel_late", 0, cyc, pe.due);
        end else begin
          for (int i = 0; i < 2; i++) begin
            chk("pixel", i, 32'(g_pix[i]), 32'(pe.pix[i]));
            chk("pix_valid", i, 32'(g_pv[i]), 32'(pe.pv[i]));
          end
        end
      end
      while (sq.size() > 0 && sq[0].due <= cyc) begin
        se = sq.pop_front();
        if (se.due != cyc) begin
          chk("state_late", 0, cyc, se.due);
        end else begin
          for (int i = 0; i < 2; i++) begin
            chk("cur_row", i, 32'(g_row[i]), 32'(se.row[i]));
            chk("cur_col", i, 32'(g_col[i]), 32'(se.col[i]));
            chk("sel_active", i, 32'(g_sel[i]), 32'(se.sel[i]));
            chk("move_from", i, 32'(g_from[i]), 32'(se.from[i]));
            chk("move_to", i, 32'(g_to[i]), 32'(se.to[i]));
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        em = 1'b0;
        foreach (mq[k])
          if (mq[k].due == cyc && mq[k].inst == i) em = 1'b1;
        chk("move_valid", i, 32'(g_mv[i]), 32'(em));
      end
      while (mq.size() > 0 && mq[0].due <= cyc)
        void'(mq.pop_front());
    end
  end

  initial begin
    int px, py;
    rst_n = 1'b1;
    drive_idle();
    model_reset();
    #1 rst_n = 1'b0;
    #2 chk_rst();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    scan(0, 0, 1);
    scan(80, 64, 1);
    scan(240, 64, 1);
    scan(1280, 0, 1);
    scan(80, 64, 0);
    scan(1279, 1023, 1);
    scan(1295, 1031, 1);
    scan(16, 8, 1);
    scan(175, 8, 1);
    scan(0, 1024, 1);

    ctl(0, 0, 0, 0, 1, 0);
    repeat (3) ctl(0, 0, 0, 1, 0, 0);
    ctl(0, 0, 0, 0, 1, 0);
    repeat (3) ctl(0, 0, 0, 0, 0, 0);
    ctl(0, 0, 0, 0, 1, 0);
    ctl(0, 0, 0, 0, 1, 0);
    repeat (2) ctl(0, 0, 0, 0, 0, 0);

    repeat (3) ctl(0, 0, 1, 0, 0, 0);
    ctl(0, 0, 1, 0, 0, 0);
    ctl(1, 1, 0, 0, 0, 0);
    ctl(0, 0, 1, 1, 0, 0);
    ctl(1, 0, 0, 0, 0, 0);
    ctl(0, 1, 0, 0, 0, 0);

    ctl(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      ctl(0, 0, 0, 0, 0, 1);
      repeat (6) ctl(0, 0, 0, 0, 0, 0);
    end
    ctl(0, 0, 0, 1, 1, 0);
    ctl(0, 1, 0, 0, 1, 0);
    repeat (3) ctl(0, 0, 0, 0, 0, 0);

    ctl(0, 0, 0, 0, 1, 0);
    ctl(0, 1, 0, 1, 0, 0);
    repeat (3) scan(330, 140, 1);
    mid_reset();
    repeat (3) ctl(0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        px = m_col[0] * TW + int'($urandom_range(0, TW - 1));
        py = m_row[0] * TH + int'($urandom_range(0, TH - 1));
      end else begin
        px = int'($urandom_range(0, 1400));
        py = int'($urandom_range(0, 1100));
      end
      step(px, py, $urandom_range(0, 7) != 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0);
    end

    scan(0, 0, 0);
    repeat (3) @(negedge clk);
    chk("pix_queue_left", 0, pq.size(), 0);
    chk("state_queue_left", 0, sq.size(), 0);
    chk("move_queue_left", 0, mq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
